// File: rtl/drain_pkg.sv
// Shared defaults and FSM encoding for the drain slave.
// Imported by drain_slave and sync_fifo.
package drain_pkg;

    localparam int DEPTH_DEF        = 4;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int DATA_W           = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head is the word at the read pointer.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
    import drain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (push && !pop): level <= level + 1'b1;
                (pop && !push): level <= level - 1'b1;
                default:        level <= level;
            endcase
        end
    end

endmodule

// File: rtl/drain_slave.sv
// Write-only slave that queues words and drains one every DRAIN_CYCLES
// edges into a running 32-bit sum.
module drain_slave
    import drain_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_clear,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [LW-1:0] ONE      = LW'(1);

    drain_state_t      state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              stay;

    // Ready comes from the level register only, so a same-edge pop
    // at full never opens the door to a push.
    assign o_ready = (o_level != FULL);
    assign push    = i_valid && o_ready;
    assign pop     = (state == WAIT) && (cnt == CNT_LAST);
    assign stay    = push || (o_level > ONE);
    assign o_busy  = (state == WAIT);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (push),
        .pop   (pop),
        .clear (i_clear),
        .din   (i_data),
        .head  (head),
        .level (o_level)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            o_data <= '0;
        end else if (i_clear) begin
            state  <= IDLE;
            cnt    <= '0;
            o_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (o_level != '0) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (pop) begin
                        o_data <= o_data + head;
                        cnt    <= '0;
                        state  <= stay ? WAIT : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drain_slave.sv
// Directed bench for drain_slave: single word, burst/full, wrap,
// clear and mid-drain reset, all against hand-computed values.
module tb_drain_slave;

    logic        i_clk;
    logic        i_rstn;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic        i_clear;
    logic [2:0]  o_level;
    logic        o_busy;

    int n_checks;
    int n_errors;

    drain_slave #(
        .DEPTH        (4),
        .DRAIN_CYCLES (3)
    ) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_data  (o_data),
        .i_clear (i_clear),
        .o_level (o_level),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_one(input logic [31:0] w);
        i_valid = 1'b1;
        i_data  = w;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rstn   = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_clear  = 1'b0;
        ticks(2);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_data",  o_data,       32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        #3 i_rstn = 1'b1;
        tick();

        // single word: accepted at edge 0, summed after edge 4
        push_one(32'h10);
        check("sw_e0_level", 32'(o_level), 32'd1);
        check("sw_e0_busy",  32'(o_busy),  32'd0);
        tick();
        check("sw_e1_busy",  32'(o_busy),  32'd1);
        tick();
        check("sw_e2_busy",  32'(o_busy),  32'd1);
        tick();
        check("sw_e3_busy",  32'(o_busy),  32'd1);
        check("sw_e3_data",  o_data,       32'd0);
        tick();
        check("sw_e4_data",  o_data,       32'h10);
        check("sw_e4_level", 32'(o_level), 32'd0);
        check("sw_e4_busy",  32'(o_busy),  32'd0);

        // burst 1..5 at full rate
        do_clear();
        check("clr_data", o_data, 32'd0);
        i_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_data = 32'(k);
            tick();
        end
        check("bu_e3_level", 32'(o_level), 32'd4);
        check("bu_e3_ready", 32'(o_ready), 32'd0);
        i_data = 32'd5;
        tick();
        check("bu_e4_level", 32'(o_level), 32'd3);
        check("bu_e4_data",  o_data,       32'd1);
        check("bu_e4_ready", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        check("bu_e5_level", 32'(o_level), 32'd4);
        tick();
        check("bu_e6_data",  o_data, 32'd1);
        tick();
        check("bu_e7_data",  o_data, 32'd3);
        ticks(3);
        check("bu_e10_data", o_data, 32'd6);
        ticks(3);
        check("bu_e13_data", o_data, 32'd10);
        ticks(3);
        check("bu_e16_data",  o_data,       32'hF);
        check("bu_e16_level", 32'(o_level), 32'd0);
        tick();
        check("bu_e17_busy",  32'(o_busy),  32'd0);

        // carry discarded
        do_clear();
        push_one(32'hFFFF_FFFF);
        push_one(32'h2);
        ticks(2);
        check("wr_e3_data", o_data, 32'd0);
        tick();
        check("wr_e4_data", o_data, 32'hFFFF_FFFF);
        ticks(3);
        check("wr_e7_data",  o_data,       32'h1);
        check("wr_e7_level", 32'(o_level), 32'd0);

        // clear with level 3 and a same-edge push
        do_clear();
        i_valid = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            i_data = 32'(k);
            tick();
        end
        i_valid = 1'b0;
        tick();
        check("cl_pre_level", 32'(o_level), 32'd3);
        check("cl_pre_data",  o_data,       32'd7);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h99;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        check("cl_level", 32'(o_level), 32'd0);
        check("cl_data",  o_data,       32'd0);
        check("cl_busy",  32'(o_busy),  32'd0);
        ticks(6);
        check("cl_lost_data",  o_data,       32'd0);
        check("cl_lost_level", 32'(o_level), 32'd0);

        // reset at cnt=1 with two words queued
        push_one(32'hA);
        push_one(32'hB);
        tick();
        check("rs_pre_level", 32'(o_level), 32'd2);
        check("rs_pre_busy",  32'(o_busy),  32'd1);
        i_rstn = 1'b0;
        #1;
        check("rs_level", 32'(o_level), 32'd0);
        check("rs_data",  o_data,       32'd0);
        check("rs_busy",  32'(o_busy),  32'd0);
        check("rs_ready", 32'(o_ready), 32'd1);
        ticks(3);
        check("rs_hold_data", o_data, 32'd0);
        i_rstn = 1'b1;
        push_one(32'h5);
        check("rs_post_level", 32'(o_level), 32'd1);
        ticks(3);
        check("rs_post_e3", o_data, 32'd0);
        tick();
        check("rs_post_e4", o_data, 32'h5);
        check("rs_post_lvl", 32'(o_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
